// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller.
// Build option: define INTR_CTRL_RR_EN for round-robin arbitration.
package intr_pkg;

    typedef enum logic [1:0] {IDLE, ARB, SERVE} intr_state_t;

    localparam int unsigned INTR_MAX_SRC     = 16;
    localparam int unsigned INTR_SRC_UART_RX = 0;
    localparam int unsigned INTR_SRC_TIMER   = 1;

    // Width of an index into n sources, never narrower than one bit.
    function automatic int unsigned intr_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Peripheral/CPU-side signal bundle of the interrupt controller.
// master: the CPU/peripheral side; slave: the controller.
// Build option: INTR_CTRL_RR_EN does not change this interface.
interface intr_ctrl_if
    import intr_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = intr_id_width(NUM_SRC)
);

    logic [NUM_SRC-1:0] src_pulse;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic               intr_en;
    logic               ack;
    logic               irq;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overflow;

    modport master (
        output src_pulse, mask_we, mask_wdata, intr_en, ack,
        input  irq, irq_id, pending, overflow
    );

    modport slave (
        input  src_pulse, mask_we, mask_wdata, intr_en, ack,
        output irq, irq_id, pending, overflow
    );

endinterface

// File: rtl/intr_arbiter.sv
// Combinational winner selection over the eligible source vector.
// Build option: INTR_CTRL_RR_EN selects round-robin starting after ptr;
// otherwise the lowest eligible index wins and there is no ptr input.
module intr_arbiter
    import intr_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = intr_id_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible,
`ifdef INTR_CTRL_RR_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

`ifdef INTR_CTRL_RR_EN
    // Scan from ptr+1 with wrap; first eligible source found wins.
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] idx_l;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        idx_l       = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx   = (32'(ptr) + 32'd1 + k) % NUM_SRC;
            idx_l = ID_W'(idx);
            if (!grant_valid && eligible[idx_l]) begin
                grant_valid = 1'b1;
                grant_id    = idx_l;
            end
        end
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        grant_id    = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!grant_valid && eligible[k]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches event pulses into pending bits, masks them,
// arbitrates one winner and holds irq/irq_id until the CPU acknowledges.
// Build option: define INTR_CTRL_RR_EN for round-robin arbitration with a
// last-served pointer; undefined gives fixed lowest-index priority.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = intr_id_width(NUM_SRC)
) (
    input  logic        clk,
    input  logic        reset,
    intr_ctrl_if.slave  bus
);

    intr_state_t        state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] overflow_q, overflow_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               irq_q;
    logic               ack_take;

    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;

    assign eligible = pending_q & mask_q;

`ifdef INTR_CTRL_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    intr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_arbiter (
        .eligible    (eligible),
        .ptr         (ptr_q),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Last-served pointer advances only when a service completes.
    always_comb begin
        ptr_d = ptr_q;
        if (ack_take) begin
            ptr_d = irq_id_q;
        end
    end

    // Pointer register; reset value makes the first search start at source 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= ID_W'(NUM_SRC - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    intr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_arbiter (
        .eligible    (eligible),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );
`endif

    // Next-state logic; ARB falls back to IDLE if the winner vanished meanwhile.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.intr_en && (|eligible)) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (bus.intr_en && grant_valid) begin
                    state_d  = SERVE;
                    irq_id_d = grant_id;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
                if (bus.ack) begin
                    ack_take = 1'b1;
                    state_d  = IDLE;
                end else if (!bus.intr_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending/overflow update; a pulse coinciding with ack keeps the source pending.
    always_comb begin
        pending_d  = pending_q | bus.src_pulse;
        overflow_d = overflow_q | (bus.src_pulse & pending_q);
        if (ack_take) begin
            pending_d[irq_id_q]  = bus.src_pulse[irq_id_q];
            overflow_d[irq_id_q] = 1'b0;
        end
    end

    // State, status and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            overflow_q <= '0;
            mask_q     <= '0;
            irq_id_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            irq_id_q   <= irq_id_d;
            irq_q      <= (state_d == SERVE);
            if (bus.mask_we) begin
                mask_q <= bus.mask_wdata;
            end
        end
    end

    assign bus.irq      = irq_q;
    assign bus.irq_id   = irq_id_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios followed by random
// traffic, checked against a behavioural model and a service-id scoreboard.
// Build option: INTR_CTRL_RR_EN switches the model to round-robin selection.
module tb_intr_ctrl;
    import intr_pkg::*;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    intr_ctrl_if #(.NUM_SRC(N)) bus ();

    intr_ctrl #(.NUM_SRC(N)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    // Reference model: what software would observe.
    logic [N-1:0] m_pend, m_ovf, m_mask;
    int           m_phase;  // 0 quiet, 1 winner being chosen, 2 in service
    int           m_id;
    int           m_last;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic int pick(input logic [N-1:0] e, input int start);
        for (int k = 0; k < N; k++) begin
            if (e[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_update();
        logic [N-1:0] elig;
        logic [N-1:0] p;
        int           start;
        if (!rst_n) begin
            m_pend = '0; m_ovf = '0; m_mask = '0;
            m_phase = 0; m_id = 0; m_last = N - 1;
            return;
        end
        p    = bus.src_pulse;
        elig = m_pend & m_mask;
        m_ovf  = m_ovf | (p & m_pend);
        m_pend = m_pend | p;
`ifdef INTR_CTRL_RR_EN
        start = (m_last + 1) % N;
`else
        start = 0;
`endif
        if (m_phase == 0) begin
            if (bus.intr_en && elig != 0) m_phase = 1;
        end else if (m_phase == 1) begin
            if (bus.intr_en && elig != 0) begin
                m_id    = pick(elig, start);
                m_phase = 2;
                exp_q.push_back(m_id);
            end else begin
                m_phase = 0;
            end
        end else begin
            if (bus.ack) begin
                m_pend[m_id] = p[m_id];
                m_ovf[m_id]  = 1'b0;
                m_last       = m_id;
                m_phase      = 0;
            end else if (!bus.intr_en) begin
                m_phase = 0;
            end
        end
        if (bus.mask_we) m_mask = bus.mask_wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("irq", int'(bus.irq), int'(m_phase == 2));
        check("pending", int'(bus.pending), int'(m_pend));
        check("overflow", int'(bus.overflow), int'(m_ovf));
        if (m_phase == 2) check("irq_id", int'(bus.irq_id), m_id);
        bus.src_pulse = '0;
        bus.mask_we   = 1'b0;
        bus.ack       = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Scoreboard monitor: every new service must match the next predicted id.
    logic prev_irq = 1'b0;
    always @(negedge clk) begin
        if (bus.irq && !prev_irq) begin
            if (exp_q.size() == 0) check("unexpected_irq", 1, 0);
            else check("sb_irq_id", int'(bus.irq_id), exp_q.pop_front());
        end
        prev_irq = bus.irq;
    end

    initial begin
        bus.src_pulse  = '0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.intr_en    = 1'b0;
        bus.ack        = 1'b0;
        m_pend = '0; m_ovf = '0; m_mask = '0;
        m_phase = 0; m_id = 0; m_last = N - 1;

        // Reset values.
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        check("rst_irq", int'(bus.irq), 0);
        check("rst_irq_id", int'(bus.irq_id), 0);
        check("rst_pending", int'(bus.pending), 0);
        check("rst_overflow", int'(bus.overflow), 0);

        // Basic service, 2-cycle latency, ack clears.
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111; bus.intr_en = 1'b1;
        tick();
        bus.src_pulse = 4'b0100;
        tick();
        check("t1_pending", int'(bus.pending), 4'b0100);
        check("t1_irq_early", int'(bus.irq), 0);
        tick();
        check("t1_irq_t1", int'(bus.irq), 0);
        tick();
        check("t1_irq", int'(bus.irq), 1);
        check("t1_id", int'(bus.irq_id), 2);
        bus.ack = 1'b1;
        tick();
        check("t1_irq_ack", int'(bus.irq), 0);
        check("t1_pend_ack", int'(bus.pending), 0);

        // Two sources pending: id 1 then id 3 with an idle gap, twice.
        for (int r = 0; r < 2; r++) begin
            bus.src_pulse = 4'b1010;
            ticks(3);
            check("t2_first", int'(bus.irq_id), 1);
            bus.ack = 1'b1;
            tick();
            check("t2_gap0", int'(bus.irq), 0);
            tick();
            check("t2_gap1", int'(bus.irq), 0);
            tick();
            check("t2_second_irq", int'(bus.irq), 1);
            check("t2_second", int'(bus.irq_id), 3);
            bus.ack = 1'b1;
            tick();
        end

        // Masked source stays pending; unmasking raises it two cycles later.
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b0000;
        tick();
        bus.src_pulse = 4'b0001;
        ticks(3);
        check("t3_irq_masked", int'(bus.irq), 0);
        check("t3_pending", int'(bus.pending), 4'b0001);
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b0001;
        ticks(3);
        check("t3_irq", int'(bus.irq), 1);
        check("t3_id", int'(bus.irq_id), 0);
        bus.ack = 1'b1;
        tick();
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
        tick();

        // Overflow and pulse coincident with ack.
        bus.src_pulse = 4'b0010;
        tick();
        bus.src_pulse = 4'b0010;
        tick();
        check("t4_overflow", int'(bus.overflow), 4'b0010);
        tick();
        check("t4_id", int'(bus.irq_id), 1);
        bus.ack = 1'b1; bus.src_pulse = 4'b0010;
        tick();
        check("t4_pend_kept", int'(bus.pending), 4'b0010);
        check("t4_ovf_clr", int'(bus.overflow), 0);
        check("t4_irq_low", int'(bus.irq), 0);
        ticks(2);
        check("t4_reassert", int'(bus.irq), 1);
        check("t4_reassert_id", int'(bus.irq_id), 1);
        bus.ack = 1'b1;
        tick();

        // Withdrawal by intr_en and restore.
        bus.src_pulse = 4'b0100;
        ticks(3);
        bus.intr_en = 1'b0;
        tick();
        check("t5_withdrawn", int'(bus.irq), 0);
        check("t5_pend_kept", int'(bus.pending), 4'b0100);
        bus.intr_en = 1'b1;
        ticks(2);
        check("t5_restored", int'(bus.irq), 1);
        check("t5_same_id", int'(bus.irq_id), 2);

        // Reset mid-service, then a stray ack in idle.
        rst_n = 1'b0;
        tick();
        check("t6_irq", int'(bus.irq), 0);
        check("t6_pending", int'(bus.pending), 0);
        check("t6_overflow", int'(bus.overflow), 0);
        rst_n = 1'b1;
        bus.ack = 1'b1;
        tick();
        check("t6_stray_ack", int'(bus.irq), 0);
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
        tick();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++) bus.src_pulse[b] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) begin
                bus.mask_we    = 1'b1;
                bus.mask_wdata = 4'($urandom_range(0, 15));
            end
            bus.intr_en = ($urandom_range(0, 9) != 0);
            bus.ack     = bus.irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            rst_n       = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        bus.intr_en = 1'b0;
        ticks(3);
        check("sb_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
